cfu_cmd_issuer: RTL and testbench

Hardware initiator for the CFU command/response interface. Accepts queued commands (function ID plus two 32-bit operands), drives them one at a time onto the CFU `cmd_*` port, collects the matching `rsp_*` result, and returns results in order through a response queue. It sits between a local sequencer or DMA front-end and the `Cfu`/TPU accelerator, so the TPU can be exercised without the CPU.

---
 rtl/cfu_pkg.sv | 27 ++
 rtl/cfu_cmd_issuer_if.sv | 25 ++
 rtl/cfu_sync_fifo.sv | 47 ++++
 rtl/cfu_cmd_issuer.sv | 211 +++++++++++++++++++++
 tb/tb_cfu_cmd_issuer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfu_pkg.sv
// Shared types and constants for the CFU command issuer.
// Optional watchdog is enabled with the CFU_ISSUER_TIMEOUT_EN macro.
package cfu_pkg;

    localparam int FUNC_W = 10;
    localparam int DATA_W = 32;
    localparam int CMD_W  = FUNC_W + 2 * DATA_W;
    localparam int RSP_W  = FUNC_W + DATA_W + 1;

    localparam logic [FUNC_W-1:0] FN_NOP      = 10'd0;
    localparam logic [FUNC_W-1:0] FN_READ_C   = 10'd3;
    localparam logic [FUNC_W-1:0] FN_READ_IDX = 10'd7;

    localparam logic [DATA_W-1:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2
    } issuer_state_t;

    // A zero in the low three function bits marks a fire-and-forget command.
    function automatic logic fn_has_rsp(input logic [FUNC_W-1:0] func);
        return (func & FN_READ_IDX) != FN_NOP;
    endfunction

endpackage

// File: rtl/cfu_cmd_issuer_if.sv
// CFU command/response bus; master is the issuer, slave is the accelerator.
interface cfu_cmd_issuer_if;

    logic                        cfu_cmd_valid;
    logic                        cfu_cmd_ready;
    logic [cfu_pkg::FUNC_W-1:0]  cfu_cmd_function_id;
    logic [cfu_pkg::DATA_W-1:0]  cfu_cmd_inputs_0;
    logic [cfu_pkg::DATA_W-1:0]  cfu_cmd_inputs_1;
    logic                        cfu_rsp_valid;
    logic                        cfu_rsp_ready;
    logic [cfu_pkg::DATA_W-1:0]  cfu_rsp_outputs_0;

    modport master (
        output cfu_cmd_valid, cfu_cmd_function_id, cfu_cmd_inputs_0, cfu_cmd_inputs_1,
        output cfu_rsp_ready,
        input  cfu_cmd_ready, cfu_rsp_valid, cfu_rsp_outputs_0
    );

    modport slave (
        input  cfu_cmd_valid, cfu_cmd_function_id, cfu_cmd_inputs_0, cfu_cmd_inputs_1,
        input  cfu_rsp_ready,
        output cfu_cmd_ready, cfu_rsp_valid, cfu_rsp_outputs_0
    );

endinterface

// File: rtl/cfu_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head reads as zero while empty.
module cfu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cfu_cmd_issuer.sv
// Drives queued commands onto the CFU bus one at a time and returns results in order.
// Define CFU_ISSUER_TIMEOUT_EN to build the response watchdog.
module cfu_cmd_issuer
    import cfu_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FUNC_W-1:0] req_func,
    input  logic [DATA_W-1:0] req_in0,
    input  logic [DATA_W-1:0] req_in1,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [FUNC_W-1:0] res_func,
    output logic              res_err,
    cfu_cmd_issuer_if.master  cfu,
    output logic              busy,
    output logic [15:0]       issued_cnt,
    output logic [15:0]       done_cnt,
    output logic              timeout_err
);

    issuer_state_t     state;
    logic              rdy_en;
    logic              cmd_valid_r;
    logic [FUNC_W-1:0] func_r;
    logic [DATA_W-1:0] in0_r;
    logic [DATA_W-1:0] in1_r;
    logic [15:0]       issued_cnt_r;
    logic [15:0]       done_cnt_r;

    logic              cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic [CMD_W-1:0]  cmd_dout;
    logic [FUNC_W-1:0] head_func;
    logic [DATA_W-1:0] head_in0;
    logic [DATA_W-1:0] head_in1;

    logic              rsp_push, rsp_pop, rsp_full, rsp_empty;
    logic [RSP_W-1:0]  rsp_dout;
    logic [DATA_W-1:0] rsp_word;
    logic              rsp_err_bit;

    logic              cmd_hs;
    logic              rsp_hs;
    logic              need_rsp;
    logic              rsp_ready_w;
    logic              tmo_block;

    cfu_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_push),
        .din   ({req_func, req_in0, req_in1}),
        .pop   (cmd_pop),
        .dout  (cmd_dout),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    cfu_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_push),
        .din   ({func_r, rsp_word, rsp_err_bit}),
        .pop   (rsp_pop),
        .dout  (rsp_dout),
        .full  (rsp_full),
        .empty (rsp_empty)
    );

    assign {head_func, head_in0, head_in1} = cmd_dout;

    // rdy_en keeps req_ready low through reset and the first cycle after it.
    assign req_ready = rdy_en & ~cmd_full;
    assign cmd_push  = req_valid & req_ready;
    assign cmd_pop   = (state == ST_IDLE) & ~cmd_empty;

    assign res_valid = ~rsp_empty;
    assign rsp_pop   = res_valid & res_ready;
    assign {res_func, res_data, res_err} = rsp_dout;

    assign need_rsp    = fn_has_rsp(func_r);
    assign rsp_ready_w = ((state == ST_ISSUE) | (state == ST_WAIT_RSP)) & ~rsp_full & ~tmo_block;
    assign cmd_hs      = cmd_valid_r & cfu.cfu_cmd_ready;
    assign rsp_hs      = cfu.cfu_rsp_valid & rsp_ready_w;

    assign cfu.cfu_cmd_valid       = cmd_valid_r;
    assign cfu.cfu_cmd_function_id = func_r;
    assign cfu.cfu_cmd_inputs_0    = in0_r;
    assign cfu.cfu_cmd_inputs_1    = in1_r;
    assign cfu.cfu_rsp_ready       = rsp_ready_w;

    assign busy       = (state != ST_IDLE) | ~cmd_empty;
    assign issued_cnt = issued_cnt_r;
    assign done_cnt   = done_cnt_r;

`ifdef CFU_ISSUER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_pend;
    logic             tmo_fire;
    logic             timeout_err_r;
    logic             awaited_hs;

    assign awaited_hs  = (state == ST_ISSUE) ? cmd_hs : rsp_hs;
    // Once pending, the abandoned command only waits for response FIFO space.
    assign tmo_fire    = (state != ST_IDLE) &
                         (tmo_pend | ((tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) & ~awaited_hs));
    assign tmo_block   = tmo_pend;
    assign timeout_err = timeout_err_r;
`else
    assign tmo_block   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        rsp_push    = 1'b0;
        rsp_word    = cfu.cfu_rsp_outputs_0;
        rsp_err_bit = 1'b0;
        case (state)
            ST_ISSUE:    rsp_push = cmd_hs & need_rsp & rsp_hs;
            ST_WAIT_RSP: rsp_push = rsp_hs;
            default:     rsp_push = 1'b0;
        endcase
`ifdef CFU_ISSUER_TIMEOUT_EN
        if (tmo_fire && !rsp_full) begin
            rsp_push    = 1'b1;
            rsp_word    = TIMEOUT_FILL;
            rsp_err_bit = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rdy_en       <= 1'b0;
            cmd_valid_r  <= 1'b0;
            func_r       <= '0;
            in0_r        <= '0;
            in1_r        <= '0;
            issued_cnt_r <= '0;
            done_cnt_r   <= '0;
`ifdef CFU_ISSUER_TIMEOUT_EN
            tmo_cnt       <= '0;
            tmo_pend      <= 1'b0;
            timeout_err_r <= 1'b0;
`endif
        end else begin
            rdy_en <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!cmd_empty) begin
                        func_r      <= head_func;
                        in0_r       <= head_in0;
                        in1_r       <= head_in1;
                        cmd_valid_r <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_hs) begin
                        issued_cnt_r <= issued_cnt_r + 16'd1;
                        cmd_valid_r  <= 1'b0;
                        if (!need_rsp) begin
                            state <= ST_IDLE;
                        end else if (rsp_hs) begin
                            done_cnt_r <= done_cnt_r + 16'd1;
                            state      <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT_RSP;
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_hs) begin
                        done_cnt_r <= done_cnt_r + 16'd1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
`ifdef CFU_ISSUER_TIMEOUT_EN
            // The counter restarts whenever the awaited handshake moves the FSM on.
            if (tmo_fire) begin
                cmd_valid_r <= 1'b0;
                if (!rsp_full) begin
                    state         <= ST_IDLE;
                    tmo_pend      <= 1'b0;
                    timeout_err_r <= 1'b1;
                    tmo_cnt       <= '0;
                end else begin
                    tmo_pend <= 1'b1;
                end
            end else if ((state != ST_IDLE) && !awaited_hs) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_cfu_cmd_issuer.sv
// Randomized scoreboard bench for cfu_cmd_issuer with a behavioural CFU responder.
module tb_cfu_cmd_issuer;
    import cfu_pkg::*;

    localparam int TMO = 16;

    typedef struct packed { logic [9:0] func; logic [31:0] a; logic [31:0] b; } cmd_t;
    typedef struct packed { logic [9:0] func; logic [31:0] data; logic err; } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [9:0]  req_func = '0;
    logic [31:0] req_in0 = '0, req_in1 = '0;
    logic        res_valid, res_ready = 1'b0, res_err;
    logic [31:0] res_data;
    logic [9:0]  res_func;
    logic        busy, timeout_err;
    logic [15:0] issued_cnt, done_cnt;

    cfu_cmd_issuer_if bus ();

    cfu_cmd_issuer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_in0(req_in0), .req_in1(req_in1),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_func(res_func), .res_err(res_err),
        .cfu(bus),
        .busy(busy), .issued_cnt(issued_cnt), .done_cnt(done_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cmd_t exp_cmd[$];
    rsp_t exp_rsp[$];
    int   exp_issued = 0, exp_done = 0;

    // responder configuration and observations
    int  cfg_stall = 0, cfg_delay = 0;
    bit  cfg_rand = 0, cfg_silent = 0;
    int  rr_mode = 0;
    bit  pend = 0, started = 0;
    int  pend_wait = 0, stall_left = 0, vcycles = 0, accept_vcycles = 0;
    logic [31:0] pend_data = '0;
    int  first_seen = 0, cap_edge = 0, acc_edge = 0, rv_rise = 0;
    bit  rv_prev = 0;

    function automatic logic [31:0] model_result(logic [9:0] f, logic [31:0] a, logic [31:0] b);
        return a * b + 32'(f >> 3);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        bus.cfu_cmd_ready = 1'b0;
        bus.cfu_rsp_valid = 1'b0;
        bus.cfu_rsp_outputs_0 = '0;
    end

    // Behavioural CFU: decides its drive for the coming edge at each negedge.
    initial begin
        cmd_t c;
        int   d;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0; started = 0;
                bus.cfu_cmd_ready = 1'b0; bus.cfu_rsp_valid = 1'b0;
                continue;
            end
            if (pend) begin
                bus.cfu_cmd_ready = 1'b0;
                if (pend_wait > 0) begin
                    pend_wait--; bus.cfu_rsp_valid = 1'b0;
                end else if (!cfg_silent) begin
                    bus.cfu_rsp_valid = 1'b1; bus.cfu_rsp_outputs_0 = pend_data;
                    if (bus.cfu_rsp_ready) begin pend = 0; cap_edge = cyc + 1; end
                end
            end else begin
                bus.cfu_rsp_valid = 1'b0;
                if (bus.cfu_cmd_valid) begin
                    if (!started) begin
                        started = 1; vcycles = 0; first_seen = cyc;
                        stall_left = cfg_rand ? $urandom_range(cfg_stall, 0) : cfg_stall;
                    end
                    vcycles++;
                    if (exp_cmd.size() == 0) begin
                        check("cmd unexpected", 1, 0);
                    end else begin
                        c = exp_cmd[0];
                        check("cmd payload", {bus.cfu_cmd_function_id, bus.cfu_cmd_inputs_0,
                              bus.cfu_cmd_inputs_1}, c);
                    end
                    if (stall_left > 0) begin
                        stall_left--; bus.cfu_cmd_ready = 1'b0;
                    end else begin
                        bus.cfu_cmd_ready = 1'b1; started = 0; accept_vcycles = vcycles;
                        if (exp_cmd.size() > 0) void'(exp_cmd.pop_front());
                        if (c.func[2:0] != 3'd0) begin
                            pend_data = model_result(c.func, c.a, c.b);
                            d = cfg_rand ? $urandom_range(cfg_delay, 0) : cfg_delay;
                            if (cfg_silent) begin
                                pend = 1; pend_wait = 0;
                            end else if (d == 0) begin
                                bus.cfu_rsp_valid = 1'b1; bus.cfu_rsp_outputs_0 = pend_data;
                                if (bus.cfu_rsp_ready) cap_edge = cyc + 1;
                                else begin pend = 1; pend_wait = 0; end
                            end else begin
                                pend = 1; pend_wait = d - 1;
                            end
                        end
                    end
                end else begin
                    bus.cfu_cmd_ready = 1'b0;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every accepted result.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin rv_prev = 0; continue; end
            if (res_valid && !rv_prev) rv_rise = cyc;
            rv_prev = res_valid;
            if (res_valid && res_ready) begin
                if (exp_rsp.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL res unexpected: got %0h/%0h expected none", res_func, res_data);
                end else begin
                    e = exp_rsp.pop_front();
                    check("res entry", {res_func, res_data, res_err}, e);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        res_ready = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? 1'b0 : 1'($urandom_range(1, 0));
    end

    // All tasks below start and end 1 time unit after a rising edge.
    task automatic send(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit silent);
        int t = 0;
        req_valid = 1'b1; req_func = f; req_in0 = a; req_in1 = b;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            @(posedge clk); #1;
            if (++t > 300) begin check("req accept timeout", 0, 1); req_valid = 1'b0; return; end
        end
        acc_edge = cyc + 1;
        exp_cmd.push_back('{f, a, b});
        exp_issued++;
        if (f[2:0] != 3'd0) begin
            if (!silent) begin
                exp_rsp.push_back('{f, model_result(f, a, b), 1'b0});
                exp_done++;
            end
`ifdef CFU_ISSUER_TIMEOUT_EN
            else exp_rsp.push_back('{f, 32'hDEAD_BEEF, 1'b1});
`endif
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int t = 0;
        forever begin
            @(negedge clk);
            if (exp_rsp.size() == 0 && exp_cmd.size() == 0 && !busy && !pend) break;
            if (++t > 3000) begin check({name, " drain timeout"}, 0, 1); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_counts(input string name);
        check({name, " issued_cnt"}, issued_cnt, 16'(exp_issued));
        check({name, " done_cnt"}, done_cnt, 16'(exp_done));
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        exp_cmd.delete(); exp_rsp.delete();
        exp_issued = 0; exp_done = 0;
        @(negedge clk);
        check("rst handshake outs", {req_ready, res_valid, bus.cfu_cmd_valid, bus.cfu_rsp_ready,
              busy, timeout_err, res_err}, 0);
        check("rst data outs", {res_data, res_func, bus.cfu_cmd_function_id,
              bus.cfu_cmd_inputs_0, bus.cfu_cmd_inputs_1}, 0);
        check("rst counters", {issued_cnt, done_cnt}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst exit outs", {req_ready, res_valid, bus.cfu_cmd_valid, bus.cfu_rsp_ready, busy}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [9:0] f;
        int t;
        @(posedge clk); #1;
        reset_dut();

        // single command, same-cycle responder
        send(10'd3, 32'd5, 32'd7, 0);
        wait_quiet("single");
        check("cmd_valid latency", first_seen, acc_edge + 1);
        check("res_valid after capture", rv_rise, cap_edge);
        check_counts("single");

        // fire-and-forget
        send(10'd0, 32'd11, 32'd12, 0);
        wait_quiet("nop");
        check_counts("nop");

        // response FIFO fills, fifth command stalls the CFU
        rr_mode = 1; cfg_delay = 3;
        for (int i = 0; i < 4; i++) send(10'd7, 32'(i + 1), 32'(i + 10), 0);
        t = 0;
        while (done_cnt != 16'(exp_done) && t < 200) begin @(posedge clk); #1; t++; end
        send(10'd7, 32'd99, 32'd2, 0);
        repeat (12) @(posedge clk);
        #1;
        @(negedge clk);
        check("full rsp_ready low", bus.cfu_rsp_ready, 0);
        check("full busy", busy, 1);
        check("full done_cnt", done_cnt, 16'(exp_done - 1));
        @(posedge clk); #1;
        rr_mode = 0;
        wait_quiet("full drain");
        check_counts("full");
        cfg_delay = 0;

        // ready held low for 10 cycles
        cfg_stall = 10;
        send(10'd3, 32'h1234, 32'h10, 0);
        wait_quiet("stall");
        check("stall accept cycle", accept_vcycles, 11);
        cfg_stall = 0;

        // silent responder
        cfg_silent = 1;
        send(10'd5, 32'd3, 32'd4, 1);
`ifdef CFU_ISSUER_TIMEOUT_EN
        t = 0;
        while (exp_rsp.size() != 0 && t < 60) begin @(posedge clk); #1; t++; end
        check("timeout entry seen", exp_rsp.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        check("timeout_err sticky", timeout_err, 1);
        check("timeout busy clear", busy, 0);
`else
        repeat (40) @(posedge clk);
        #1;
        check("silent busy held", busy, 1);
        check("silent no result", res_valid, 0);
        check_counts("silent");
`endif
        reset_dut();

        // reset while waiting for a response
        send(10'd6, 32'd8, 32'd8, 1);
        repeat (5) @(posedge clk);
        #1;
        check("wait busy", busy, 1);
        reset_dut();
        cfg_silent = 0;
        send(10'd3, 32'd9, 32'd4, 0);
        wait_quiet("post reset");
        check_counts("post reset");

        // randomized traffic
        cfg_rand = 1; cfg_stall = 2; cfg_delay = 3; rr_mode = 2;
        for (int i = 0; i < 150; i++) begin
            f = 10'($urandom);
            if ($urandom_range(3, 0) == 0) f[2:0] = 3'd0;
            send(f, $urandom, $urandom, 0);
            if ($urandom_range(3, 0) == 0) begin repeat ($urandom_range(4, 1)) @(posedge clk); #1; end
        end
        rr_mode = 0;
        wait_quiet("random");
        check_counts("random");
        check("random timeout_err", timeout_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
